// File: rtl/mem_port_arbiter_if.sv
// Request/response channel shared by the IFU, LSU and memory sides of mem_port_arbiter.
// The master drives the request and receives the in-order response; the slave does the opposite.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int DATA_BYTE = DATA_WIDTH / 8;

  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  we;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_BYTE-1:0]  strobe;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output req_valid, addr, we, wdata, strobe,
    input  req_ready, rsp_valid, rdata
  );

  modport slave (
    input  req_valid, addr, we, wdata, strobe,
    output req_ready, rsp_valid, rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IFU (read-only) and LSU, LSU priority, in-order response routing.
// Define ARB_STARVE_GUARD_EN to force an IFU grant after STARVE_LIMIT stalled IFU cycles.
//
// state    | meaning
// IDLE     | arbitrate each cycle; accepted requests never leave IDLE
// HOLD_IFU | IFU request presented but not yet accepted, mux frozen on IFU
// HOLD_LSU | LSU request presented but not yet accepted, mux frozen on LSU
module mem_port_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  mem_port_arbiter_if.slave    ifu_if,
  mem_port_arbiter_if.slave    lsu_if,
  mem_port_arbiter_if.master   mem_if
);
  localparam int PW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int IW = $clog2(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD_IFU = 2'd1,
    HOLD_LSU = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [MAX_OUTSTANDING-1:0] owner_q, owner_d;

  logic [PW-1:0] count;
  logic          fifo_empty;
  logic          fifo_full;
  logic          pop;
  logic          head_lsu;
  logic          force_ifu;
  logic          sel_lsu;
  logic          req_valid;
  logic          mem_valid;
  logic          accept;
  logic          ifu_acc;
  logic          unused_ifu_wr;

  assign count      = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (count == '0);
  assign pop        = mem_if.rsp_valid & ~fifo_empty;
  // A same-cycle pop frees a slot, so a full FIFO can still take a push.
  assign fifo_full  = (count == PW'(MAX_OUTSTANDING)) & ~pop;
  assign head_lsu   = owner_q[rd_ptr_q[IW-1:0]];

  always_comb begin
    sel_lsu   = 1'b0;
    req_valid = 1'b0;
    unique case (state_q)
      HOLD_IFU: begin
        sel_lsu   = 1'b0;
        req_valid = 1'b1;
      end
      HOLD_LSU: begin
        sel_lsu   = 1'b1;
        req_valid = 1'b1;
      end
      default: begin
        sel_lsu   = lsu_if.req_valid & ~(force_ifu & ifu_if.req_valid);
        req_valid = (ifu_if.req_valid | lsu_if.req_valid) & ~fifo_full;
      end
    endcase
  end

  // Outputs are combinational, so gate with rst_n to keep them quiet during reset.
  assign mem_valid = req_valid & rst_n;
  assign accept    = mem_valid & mem_if.req_ready;
  assign ifu_acc   = accept & ~sel_lsu;

  assign mem_if.req_valid = mem_valid;
  assign mem_if.addr      = !mem_valid ? '0 : (sel_lsu ? lsu_if.addr : ifu_if.addr);
  assign mem_if.we        = mem_valid & sel_lsu & lsu_if.we;
  assign mem_if.wdata     = (mem_valid & sel_lsu) ? lsu_if.wdata : '0;
  assign mem_if.strobe    = (mem_valid & sel_lsu) ? lsu_if.strobe : '0;

  assign ifu_if.req_ready = ifu_acc;
  assign lsu_if.req_ready = accept & sel_lsu;

  assign ifu_if.rsp_valid = pop & ~head_lsu;
  assign ifu_if.rdata     = (pop & ~head_lsu) ? mem_if.rdata : '0;
  assign lsu_if.rsp_valid = pop & head_lsu;
  assign lsu_if.rdata     = (pop & head_lsu) ? mem_if.rdata : '0;

  assign unused_ifu_wr = ^{ifu_if.we, ifu_if.wdata, ifu_if.strobe};

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q + PW'(accept);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    owner_d  = owner_q;
    if (accept) owner_d[wr_ptr_q[IW-1:0]] = sel_lsu;
    if (state_q == IDLE) begin
      if (mem_valid && !mem_if.req_ready) state_d = sel_lsu ? HOLD_LSU : HOLD_IFU;
    end else if (mem_if.req_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      owner_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      owner_q  <= owner_d;
    end
  end

`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_q, starve_d;

  assign force_ifu = (starve_q == SW'(STARVE_LIMIT));

  always_comb begin
    starve_d = starve_q;
    if (ifu_acc)                               starve_d = '0;
    else if (ifu_if.req_valid && !force_ifu)   starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_q <= '0;
    else        starve_q <= starve_d;
  end
`else
  localparam int unused_starve_limit = STARVE_LIMIT;
  assign force_ifu = 1'b0;
`endif

  a_no_rsp_when_empty : assert property (
    @(posedge clk) disable iff (!rst_n) !(mem_if.rsp_valid && fifo_empty)
  ) else $error("mem_port_arbiter: memory response with no outstanding request");

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a queue-based reference of the arbitration rules.
// Honours ARB_STARVE_GUARD_EN the same way as the design.
module tb_mem_port_arbiter;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifu_if ();
  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) lsu_if ();
  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

  mem_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ifu_if(ifu_if), .lsu_if(lsu_if), .mem_if(mem_if)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference state: owners of outstanding requests, the data memory will return, hold and starve.
  int            owner_m[$];
  logic [DW-1:0] rdata_m[$];
  bit            hold_m;
  int            hold_own;
  int            starve_m;
  bit            ifu_pend;
  bit            lsu_pend;

  task automatic reset_model();
    owner_m.delete();
    rdata_m.delete();
    hold_m   = 0;
    hold_own = 0;
    starve_m = 0;
    ifu_pend = 0;
    lsu_pend = 0;
  endtask

  task automatic check_quiet(input string pfx);
    check({pfx, "_mem_req_valid"}, 64'(mem_if.req_valid), 64'd0);
    check({pfx, "_mem_addr"},      64'(mem_if.addr),      64'd0);
    check({pfx, "_mem_we"},        64'(mem_if.we),        64'd0);
    check({pfx, "_mem_wdata"},     64'(mem_if.wdata),     64'd0);
    check({pfx, "_mem_strobe"},    64'(mem_if.strobe),    64'd0);
    check({pfx, "_ifu_ready"},     64'(ifu_if.req_ready), 64'd0);
    check({pfx, "_lsu_ready"},     64'(lsu_if.req_ready), 64'd0);
    check({pfx, "_ifu_rsp"},       64'(ifu_if.rsp_valid), 64'd0);
    check({pfx, "_lsu_rsp"},       64'(lsu_if.rsp_valid), 64'd0);
    check({pfx, "_ifu_data"},      64'(ifu_if.rdata),     64'd0);
    check({pfx, "_lsu_data"},      64'(lsu_if.rdata),     64'd0);
  endtask

  // Called just after a falling edge; drives, checks, advances the model, returns after next falling edge.
  task automatic run_cycle(input int pi, input int pl, input int pr, input int prv);
    bit pop, full, exp_v, sel_l, force_i, acc, ifu_v, lsu_v;
    if (!ifu_pend) begin
      ifu_if.req_valid = ($urandom_range(99) < pi);
      ifu_if.addr      = $urandom;
    end
    if (!lsu_pend) begin
      lsu_if.req_valid = ($urandom_range(99) < pl);
      lsu_if.addr      = $urandom;
      lsu_if.we        = $urandom_range(1);
      lsu_if.wdata     = $urandom;
      lsu_if.strobe    = 4'($urandom_range(15));
    end
    mem_if.req_ready = ($urandom_range(99) < pr);
    if (rdata_m.size() > 0 && $urandom_range(99) < prv) begin
      mem_if.rsp_valid = 1'b1;
      mem_if.rdata     = rdata_m[0];
    end else begin
      mem_if.rsp_valid = 1'b0;
      mem_if.rdata     = $urandom;
    end
    #1;
    ifu_v = ifu_if.req_valid;
    lsu_v = lsu_if.req_valid;
    pop   = mem_if.rsp_valid;
    full  = (owner_m.size() == DEPTH) && !pop;
    if (hold_m) begin
      exp_v = 1;
      sel_l = (hold_own == 1);
    end else begin
      force_i = GUARD && (starve_m >= LIMIT);
      exp_v   = (ifu_v || lsu_v) && !full;
      sel_l   = lsu_v && !(force_i && ifu_v);
    end
    acc = exp_v && mem_if.req_ready;

    check("mem_req_valid", 64'(mem_if.req_valid), 64'(exp_v));
    if (exp_v) begin
      check("mem_addr", 64'(mem_if.addr), sel_l ? 64'(lsu_if.addr) : 64'(ifu_if.addr));
      check("mem_we", 64'(mem_if.we), sel_l ? 64'(lsu_if.we) : 64'd0);
      check("mem_strobe", 64'(mem_if.strobe), sel_l ? 64'(lsu_if.strobe) : 64'd0);
      if (sel_l) check("mem_wdata", 64'(mem_if.wdata), 64'(lsu_if.wdata));
    end
    check("ifu_req_ready", 64'(ifu_if.req_ready), 64'(acc && !sel_l));
    check("lsu_req_ready", 64'(lsu_if.req_ready), 64'(acc && sel_l));
    if (pop) begin
      check("ifu_rsp_valid", 64'(ifu_if.rsp_valid), 64'(owner_m[0] == 0));
      check("lsu_rsp_valid", 64'(lsu_if.rsp_valid), 64'(owner_m[0] == 1));
      if (owner_m[0] == 0) check("ifu_data", 64'(ifu_if.rdata), 64'(rdata_m[0]));
      else                 check("lsu_data", 64'(lsu_if.rdata), 64'(rdata_m[0]));
    end else begin
      check("ifu_rsp_idle", 64'(ifu_if.rsp_valid), 64'd0);
      check("lsu_rsp_idle", 64'(lsu_if.rsp_valid), 64'd0);
    end

    if (pop) begin
      void'(owner_m.pop_front());
      void'(rdata_m.pop_front());
    end
    if (acc) begin
      owner_m.push_back(sel_l ? 1 : 0);
      rdata_m.push_back($urandom);
      hold_m = 0;
    end else if (exp_v && !hold_m) begin
      hold_m   = 1;
      hold_own = sel_l ? 1 : 0;
    end
    if (acc && !sel_l)                  starve_m = 0;
    else if (ifu_v && starve_m < LIMIT) starve_m++;
    ifu_pend = ifu_v && !(acc && !sel_l);
    lsu_pend = lsu_v && !(acc && sel_l);
    @(negedge clk);
  endtask

  task automatic run_phase(input int n, input int pi, input int pl, input int pr, input int prv);
    for (int i = 0; i < n; i++) run_cycle(pi, pl, pr, prv);
  endtask

  initial begin
    reset_model();
    ifu_if.we        = 1'b0;
    ifu_if.wdata     = '0;
    ifu_if.strobe    = '0;
    ifu_if.req_valid = 1'b1;
    ifu_if.addr      = 32'h0000_0010;
    lsu_if.req_valid = 1'b1;
    lsu_if.addr      = 32'h0000_0100;
    lsu_if.we        = 1'b1;
    lsu_if.wdata     = 32'hDEAD_BEEF;
    lsu_if.strobe    = 4'hF;
    mem_if.req_ready = 1'b1;
    mem_if.rsp_valid = 1'b1;
    mem_if.rdata     = 32'h1234_5678;

    // Reset with every request asserted: everything must stay quiet.
    @(negedge clk);
    @(negedge clk);
    check_quiet("rst");
    mem_if.rsp_valid = 1'b0;
    ifu_if.req_valid = 1'b0;
    lsu_if.req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    run_phase(150, 60, 60, 70, 60);   // mixed traffic
    run_phase(60, 100, 100, 100, 50); // sustained contention
    run_phase(60, 80, 40, 20, 50);    // long holds
    run_phase(30, 100, 50, 100, 0);   // fill the owner FIFO
    run_phase(20, 0, 0, 0, 100);      // drain responses
    run_phase(60, 70, 30, 80, 40);

    // Asynchronous reset in the middle of the cycle, with requests still outstanding.
    run_phase(20, 100, 100, 100, 0);
    #2;
    rst_n = 1'b0;
    ifu_if.req_valid = 1'b1;
    lsu_if.req_valid = 1'b1;
    mem_if.req_ready = 1'b1;
    mem_if.rsp_valid = 1'b0;
    #1;
    check_quiet("midrst");
    reset_model();
    @(negedge clk);
    @(negedge clk);
    ifu_if.req_valid = 1'b0;
    lsu_if.req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    run_phase(30, 100, 50, 100, 0);   // FIFO must hold exactly DEPTH again
    run_phase(150, 60, 60, 70, 60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
